// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and helpers for the PS/2 host transmitter
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    BITS,
    ACK,
    ACK_END,
    DONE,
    ERR
  } state_e;

  localparam int FRAME_BITS = 10;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-flop synchronizer plus stability counter for one PS/2 line
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic filt_o
);

  localparam int CW = $clog2(FILTER_CYCLES) + 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Idle PS/2 lines float high, so every stage resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_CYCLES  = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wen,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  state_e                  state_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [3:0]              bitcnt_q;
  logic [IW-1:0]           inh_cnt_q;
  logic [TW-1:0]           to_cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;
  logic                    clk_oe_q;
  logic                    data_oe_q;
  logic                    clk_prev_q;

  logic clk_f;
  logic data_f;
  logic fall;
  logic timed;
  logic tmo_hit;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_clk_in),
    .filt_o (clk_f)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filt (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_data_in),
    .filt_o (data_f)
  );

  assign fall    = clk_prev_q & ~clk_f;
  assign timed   = (state_q == START) || (state_q == BITS) ||
                   (state_q == ACK)   || (state_q == ACK_END);
  assign tmo_hit = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      clk_prev_q <= clk_f;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      // Timeout wins over any falling edge seen in the same cycle.
      if (timed && tmo_hit) begin
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        error_q   <= 1'b1;
        state_q   <= ERR;
      end else begin
        if (timed) to_cnt_q <= to_cnt_q + 1'b1;
        case (state_q)
          IDLE: begin
            if (wen) begin
              shift_q   <= {1'b1, odd_parity(wdata), wdata};
              inh_cnt_q <= '0;
              busy_q    <= 1'b1;
              clk_oe_q  <= 1'b1;
              state_q   <= INHIBIT;
            end
          end
          INHIBIT: begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
            if (inh_cnt_q == IW'(INHIBIT_CYCLES - 2)) data_oe_q <= 1'b1;
            if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
              clk_oe_q <= 1'b0;
              to_cnt_q <= '0;
              state_q  <= START;
            end
          end
          START: begin
            if (fall) begin
              data_oe_q <= ~shift_q[0];
              shift_q   <= {1'b0, shift_q[FRAME_BITS-1:1]};
              bitcnt_q  <= 4'd1;
              state_q   <= BITS;
            end
          end
          BITS: begin
            if (fall) begin
              data_oe_q <= ~shift_q[0];
              shift_q   <= {1'b0, shift_q[FRAME_BITS-1:1]};
              bitcnt_q  <= bitcnt_q + 1'b1;
              if (bitcnt_q == 4'(FRAME_BITS - 1)) state_q <= ACK;
            end
          end
          ACK: begin
            if (fall) begin
              if (!data_f) begin
                state_q <= ACK_END;
              end else begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                error_q   <= 1'b1;
                state_q   <= ERR;
              end
            end
          end
          ACK_END: begin
            if (clk_f && data_f) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          ERR: begin
            busy_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign rx_inhibit  = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, ...) from the CPU's keyboard MMIO path to the keyboard over the shared open-drain PS/2 clock and data lines. It sits beside the existing PS/2 receive path in the keyboard subsystem. While it owns the bus it holds `rx_inhibit` high so the receive path discards edges.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the PS/2 clock is held low before the start bit (≥100 µs at 50 MHz)
TIMEOUT_CYCLES, 1000000, max clk cycles from clock release to acknowledge completion (20 ms at 50 MHz)
FILTER_CYCLES, 19, consecutive stable samples before a filtered line changes

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
wen  in  1  start request; sampled only in IDLE
wdata  in  8  command byte
busy  out  1  high from the cycle after an accepted wen until the cycle after done/error
done  out  1  one-cycle pulse: byte sent and device acknowledged
error  out  1  one-cycle pulse: timeout or missing acknowledge
rx_inhibit  out  1  equals busy
ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
ps2_data_in  in  1  raw PS/2 data line (asynchronous)
ps2_clk_oe  out  1  1 = pull clock line low, 0 = release
ps2_data_oe  out  1  1 = pull data line low, 0 = release

Behaviour:
- Reset (asynchronous): state IDLE. busy, done, error, rx_inhibit, ps2_clk_oe and ps2_data_oe are all 0, and both lines are released immediately. Filtered lines reset to 1.
- Input filtering: 2-flop synchronizer, then a stability counter. A filtered line takes the new value after FILTER_CYCLES equal consecutive samples.
- Falling edge: filtered clock goes 1→0. It is registered and acted on in the cycle after the filtered change.
- Frame is shift = {1 (stop), odd parity, wdata[7:0]}, sent LSB first. Parity = ~^wdata.
- IDLE:
  - A wen pulse latches wdata and builds the frame; next state INHIBIT.
  - wen in any other state is ignored and the data is not latched.
- INHIBIT:
  - ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles.
  - ps2_data_oe rises to 1 in the last inhibit cycle.
  - Next state START, with the timeout counter cleared.
- START:
  - ps2_clk_oe = 0, ps2_data_oe = 1 (start bit 0).
  - On a falling edge, drive frame bit 0 (ps2_data_oe = ~bit), set bitcnt = 1, go to BITS.
- BITS:
  - On each falling edge, drive the next frame bit and increment bitcnt.
  - The edge with bitcnt = 9 drives the stop bit (data released) and moves to ACK.
  - Data changes only on falling edges; the device samples on rising edges.
- ACK:
  - On the next falling edge, sample filtered data. Low → ACK_END. High → ERR.
- ACK_END: wait until both filtered clock and data are 1, then go to DONE.
- DONE: done = 1 for one cycle; next state IDLE, where busy drops.
- ERR:
  - error = 1 for one cycle; next state IDLE.
  - Both oe outputs are 0 in ERR and remain 0.
- Timeout:
  - Counter runs in START, BITS, ACK and ACK_END.
  - Reaching TIMEOUT_CYCLES from any of these → ERR, with both lines released in the same cycle.
  - Timeout has priority over a simultaneous falling edge.
- Bus ownership: the device holding the clock low during INHIBIT has no effect; the host wins by design.
- Output registering: all outputs are registered, with no combinational path from wen to any output. done and error are never high together.
- Counter widths: counters are sized by $clog2 of their parameter + 1 and must not wrap before the limit.

Decomposition:
- Package ps2_pkg holds:
  - state enum (IDLE, INHIBIT, START, BITS, ACK, ACK_END, DONE, ERR)
  - FRAME_BITS = 10
  - function odd_parity(byte)
- Sub-module ps2_line_filter (synchronizer + stability counter, parameter FILTER_CYCLES), instantiated once per line.
- The FSM, shift register and counters stay in ps2_host_tx.

Test Plan:
- INHIBIT_CYCLES = 20: wen with 0xED → ps2_clk_oe high for exactly 20 cycles, ps2_data_oe high from cycle 20; busy and rx_inhibit high from the cycle after wen.
- Device model clocks at 10 kHz-equivalent, samples on rising edges, acks. Send 0xED, 0xFF, 0x00, 0x01 → captured bits are start = 0, data LSB first, parity 1/1/1/0, stop = 1; done pulses once; busy drops the cycle after.
- Device does not pull data low on the 11th edge → error pulse, no done, both oe = 0, state IDLE.
- TIMEOUT_CYCLES = 500, device never clocks → error exactly 500 cycles after START is entered; lines released in the same cycle.
- Second wen (0xAA) during BITS of a 0xF3 transfer → ignored; wire carries only 0xF3 with parity 1; one done.
- rst asserted mid-BITS → ps2_clk_oe, ps2_data_oe and busy are 0 asynchronously; a new wen after deassert sends a complete correct frame.
